// File: rtl/rca8_seq_add64.sv
// ---------------------------------------------------------------------------
// rca8_seq_add64 -- byte-serial add/subtract unit built around one 8-bit
// ripple-carry adder (rca8). A WIDTH-bit sum or difference is produced one
// byte per clock, LSB byte first, in WIDTH/8 cycles. This is the small-area
// alternative to the full-width combinational adder path.
//
// Optional feature macro: ABORT_MODE_EN (adds the abort input).
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     operation request, accepted only while ready=1
//   op_sub    0 = a+b, 1 = a-b (sampled with start)
//   a, b      WIDTH-bit operands (sampled with start)
//   abort     (ABORT_MODE_EN only) cancel the operation in progress
//   ready     high in IDLE
//   busy      high in RUN
//   done      one-cycle completion pulse
//   result    result of the last completed operation
//   c_out     carry out of the MSB (subtract: 1 = no borrow)
//   overflow  signed two's-complement overflow of the last operation
//   zero      result == 0
// ---------------------------------------------------------------------------

// 8-bit ripple-carry adder: the single arithmetic slice the controller reuses.
module rca8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       c_in,
  output logic [7:0] z,
  output logic       c_out
);
  logic carry;

  // NOTE: blocking assignments are correct here: this is combinational logic
  // and 'carry' must ripple bit by bit within one evaluation.
  always_comb begin
    carry = c_in;
    z     = '0;
    for (int i = 0; i < 8; i++) begin
      z[i]  = x[i] ^ y[i] ^ carry;
      carry = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
    c_out = carry;
  end
endmodule

module rca8_seq_add64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ABORT_MODE_EN
  input  logic             abort,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  if ((WIDTH % 8) != 0 || WIDTH < 16) begin : g_bad_width
    $error("rca8_seq_add64: WIDTH must be a multiple of 8 and at least 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opb_q, acc_q, acc_d;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] result_q;
  logic             c_out_q, overflow_q, zero_q;

  logic [7:0]       byte_z;
  logic             byte_co;
  logic             abort_hit;
  logic             last_byte;

`ifdef ABORT_MODE_EN
  assign abort_hit = (state_q == RUN) && abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign last_byte = (idx_q == LAST_IDX);

  // The one shared adder slice, steered to the current byte lane.
  rca8 u_rca8 (
    .x     (opa_q[{idx_q, 3'b000} +: 8]),
    .y     (opb_q[{idx_q, 3'b000} +: 8]),
    .c_in  (carry_q),
    .z     (byte_z),
    .c_out (byte_co)
  );

  // Accumulator with the current byte merged in, so the final byte is already
  // visible when the result registers load on the last RUN edge.
  always_comb begin
    acc_d = acc_q;
    acc_d[{idx_q, 3'b000} +: 8] = byte_z;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves state_d unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (abort_hit)      state_d = IDLE;  // abort beats completion
        else if (last_byte) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_q      <= '0;
      opb_q      <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      result_q   <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            opa_q   <= a;
            opb_q   <= op_sub ? ~b : b;
            carry_q <= op_sub;
            idx_q   <= '0;
          end
        end
        RUN: begin
          if (!abort_hit) begin
            acc_q   <= acc_d;
            carry_q <= byte_co;
            idx_q   <= idx_q + IDX_W'(1);
            if (last_byte) begin
              result_q   <= acc_d;
              c_out_q    <= byte_co;
              overflow_q <= (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                            (acc_d[WIDTH-1] != opa_q[WIDTH-1]);
              zero_q     <= (acc_d == '0);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decode the state register only.
  assign ready    = (state_q == IDLE);
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign c_out    = c_out_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_rca8_seq_add64.sv
// ---------------------------------------------------------------------------
// tb_rca8_seq_add64 -- directed bench for rca8_seq_add64 (WIDTH=64).
// Expected results come from a full-width reference model, queued when an
// operation is issued and popped when done is observed. Define ABORT_MODE_EN
// to also exercise the abort path.
// ---------------------------------------------------------------------------
module tb_rca8_seq_add64;
  localparam int WIDTH  = 64;
  localparam int NBYTES = WIDTH / 8;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             ov;
    logic             z;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, op_sub, abort;
  logic [WIDTH-1:0] a, b;
  logic             ready, busy, done, c_out, overflow, zero;
  logic [WIDTH-1:0] result;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t last;

  always #5 clk = ~clk;

  rca8_seq_add64 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_sub   (op_sub),
    .a        (a),
    .b        (b),
`ifdef ABORT_MODE_EN
    .abort    (abort),
`endif
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .c_out    (c_out),
    .overflow (overflow),
    .zero     (zero)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] av, bv,
                                 input logic sub);
    exp_t           m;
    logic [WIDTH-1:0] be;
    logic [WIDTH:0]   s;
    be   = sub ? ~bv : bv;
    s    = {1'b0, av} + {1'b0, be} + (WIDTH+1)'(sub);
    m.res = s[WIDTH-1:0];
    m.c   = s[WIDTH];
    m.ov  = (av[WIDTH-1] == be[WIDTH-1]) && (s[WIDTH-1] != av[WIDTH-1]);
    m.z   = (s[WIDTH-1:0] == '0);
    return m;
  endfunction

  // Issue one operation and follow it to completion. restart_at re-asserts
  // start with a=1,b=1 at that RUN cycle; rst_at pulses reset at that cycle.
  task automatic run_op(input logic [WIDTH-1:0] av, bv, input logic sub,
                        input int restart_at, input int rst_at);
    exp_t e;
    int   k, busy_n, extra;
    @(negedge clk);
    start = 1'b1; a = av; b = bv; op_sub = sub;
    sb.push_back(model(av, bv, sub));
    @(posedge clk);
    k = 0; busy_n = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        // Operands are free to change after the sampling edge.
        start = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom};
        op_sub = ~sub;
      end
      if (k == restart_at) begin
        start = 1'b1; a = 1; b = 1; op_sub = 1'b0;
      end
      if (k == 4) check("hold_result", result, last.res);
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flags", {c_out, overflow, zero}, 0);
        void'(sb.pop_front());
        last = '0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (busy) busy_n++;
      if (done) break;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("latency", k, NBYTES + 1);
    check("busy_cycles", busy_n, NBYTES);
    check("sb_depth", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("result", result, e.res);
      check("c_out", c_out, e.c);
      check("overflow", overflow, e.ov);
      check("zero", zero, e.z);
      last = e;
    end
    @(negedge clk);
    check("done_pulse_len", done, 0);
    check("ready_after", ready, 1);
    if (restart_at > 0) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("extra_done", extra, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; abort = 1'b0; a = '0; b = '0;
    last = '0;
    #1;
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    check("reset_flags", {c_out, overflow, zero}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 0);   // all-ones + 1
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 0, 0);   // signed overflow
    run_op(64'h5, 64'h7, 1'b1, 0, 0);                     // borrow
    run_op(64'h00FF_00FF_00FF_00FF, 64'h0001_0001_0001_0001, 1'b0, 0, 0);
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 3, 0);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0, 4);   // reset mid-run
    run_op(64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b1, 0, 0);

`ifdef ABORT_MODE_EN
    begin
      int extra;
      @(negedge clk);
      start = 1'b1; a = 64'h1111; b = 64'h2222; op_sub = 1'b0;
      @(posedge clk);
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (k == 3) abort = 1'b1;
      end
      @(negedge clk);
      abort = 1'b0;
      check("abort_ready", ready, 1);
      check("abort_done", done, 0);
      check("abort_result", result, last.res);
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (done) extra++;
      end
      check("abort_no_done", extra, 0);
      run_op(64'h1111, 64'h2222, 1'b0, 0, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rca8_seq_add64.md
Name: rca8_seq_add64

Overview:
- Byte-serial add/subtract controller that owns one rca8 (8-bit ripple-carry adder) instance.
- Drives that instance once per clock to produce a WIDTH-bit sum or difference in WIDTH/8 cycles.
- Sits beside the combinational 64-bit adder path as an area-reduced alternative unit.
- Host side uses a start/ready/done handshake.

Parameters:
- WIDTH, 64, operand width in bits; must be a multiple of 8 and at least 16. NBYTES = WIDTH/8 (derived, not overridable).

Ports:
- clk  input  1  single clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- op_sub  input  1  0 = a+b, 1 = a-b; sampled with start
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- ready  output  1  high in IDLE
- busy  output  1  high in RUN
- done  output  1  one-cycle completion pulse
- result  output  WIDTH  registered result of last completed op
- c_out  output  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  output  1  signed two's-complement overflow
- zero  output  1  result == 0
- abort  input  1  present only with ABORT_MODE_EN

Behaviour:
- Reset: async, active-high. state=IDLE; result=0, c_out=0, overflow=0, zero=0, done=0, busy=0, ready=1. Internal byte index, carry and accumulator are cleared.
- Reset mid-operation: any state, including RUN, goes to IDLE immediately. No done pulse. Result and flags read 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - On start=1 at a rising edge: latch a into opa_q. Latch b_eff = op_sub ? ~b : b into opb_q. Set carry_q = op_sub. Set idx=0. Go to RUN.
- RUN:
  - busy=1.
  - Each edge: rca8 x = opa_q byte idx, y = opb_q byte idx, c_in = carry_q. Its z is written into accumulator byte idx. carry_q <= c_out. idx increments.
  - At the edge processing idx = NBYTES-1, go to DONE.
  - Load the output registers from the final values on that same edge:
    - result = full accumulator, including the final byte.
    - c_out = final carry.
    - overflow = (opa_q[MSB] == opb_q[MSB]) && (result[MSB] != opa_q[MSB]).
    - zero = (result == 0).
- DONE:
  - done=1 for exactly one cycle. Next edge goes to IDLE.
  - start is not accepted in DONE.
- Latency: start is sampled at edge E0. Bytes are computed at E1..E(NBYTES). done is high in the cycle following E(NBYTES), which is E8 for WIDTH=64. Throughput is one op per NBYTES+2 cycles.
- start while busy, or in DONE: ignored. Operands are not re-sampled and there is no error indication.
- start held high continuously: a new op is accepted at each IDLE visit.
- result, c_out, overflow and zero:
  - Change only when entering DONE, or on reset.
  - Are held stable through a subsequent RUN until the new op completes.
- Input stability: a, b and op_sub may change freely after the sampling edge.
- Outputs ready, busy and done are decoded from the state register only; no combinational path from inputs.
- Width rule: the carry chain propagates strictly LSB byte to MSB byte. Carry out of the top byte is c_out; there is no wrap into byte 0.

Optional Feature:
- Macro ABORT_MODE_EN.
- When defined:
  - The abort input port exists.
  - abort=1 at an edge while in RUN returns the FSM to IDLE on that edge.
  - No done pulse is produced.
  - result and flags keep their previous completed values.
  - abort has priority over completion at idx = NBYTES-1.
  - abort is ignored in IDLE and DONE.
- When undefined: no abort port; RUN always runs NBYTES cycles to completion.

Test Plan:
- Add all-ones: a=0xFFFF_FFFF_FFFF_FFFF, b=1, op_sub=0 -> result=0, c_out=1, zero=1, overflow=0. done high exactly in the cycle after the 8th edge following start; busy high for 8 cycles.
- Signed overflow on subtract: a=0x8000_0000_0000_0000, b=1, op_sub=1 -> result=0x7FFF_FFFF_FFFF_FFFF, overflow=1, c_out=1, zero=0.
- Borrow: a=5, b=7, op_sub=1 -> result=0xFFFF_FFFF_FFFF_FFFE, c_out=0, overflow=0.
- Carry across bytes: a=0x00FF_00FF_00FF_00FF, b=0x0001_0001_0001_0001, op_sub=0 -> result=0x0100_0100_0100_0100, c_out=0.
- start re-asserted during RUN with a=1, b=1 -> ignored; the first op's result is reported; only one done pulse.
- rst pulsed during RUN cycle 4 -> all outputs 0 and ready=1 immediately, no done; the next op completes correctly.
- With ABORT_MODE_EN, abort in RUN cycle 3 -> IDLE at the next edge, no done, and result equals the previous op's value.
